// File: rtl/mont_enter_serial.sv
// Forward Montgomery conversion T = A * 2^SHIFT mod q by serial modular doubling.
// Ports: clk, rst (async active-low), q/A/in_valid/in_ready in, T/out_valid/out_ready out.
// Optional: define MONT_ENTER_RANGE_CHK_EN to add the err output (q MSB clear).
module mont_enter_serial #(
  parameter int Q_LEN = 60,
  parameter int SHIFT = Q_LEN,
  parameter int STEPS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [Q_LEN-1:0] q,
  input  logic [Q_LEN-1:0] A,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [Q_LEN-1:0] T,
  output logic             out_valid,
`ifdef MONT_ENTER_RANGE_CHK_EN
  output logic             err,
`endif
  input  logic             out_ready
);

  localparam int N  = SHIFT / STEPS;
  localparam int CW = $clog2(N + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PRE  = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]       state;
  logic [Q_LEN-1:0] x;
  logic [Q_LEN-1:0] q_r;
  logic [CW-1:0]    cnt;
  logic [Q_LEN-1:0] x_pre;
  logic [Q_LEN-1:0] x_nxt;
  logic [Q_LEN:0]   d;
  logic [Q_LEN:0]   s;

  // q has its MSB set, so one subtraction brings any A below q.
  always_comb begin
    x_pre = x;
    if (x >= q_r)
      x_pre = x - q_r;
  end

  // STEPS chained doublings; compare on the full Q_LEN+1 bit value.
  always_comb begin
    x_nxt = x;
    d     = '0;
    s     = '0;
    for (int i = 0; i < STEPS; i++) begin
      d = {x_nxt, 1'b0};
      s = d - {1'b0, q_r};
      if (d >= {1'b0, q_r})
        x_nxt = s[Q_LEN-1:0];
      else
        x_nxt = d[Q_LEN-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      x     <= '0;
      q_r   <= '0;
      cnt   <= '0;
`ifdef MONT_ENTER_RANGE_CHK_EN
      err   <= 1'b0;
`endif
    end else begin
      unique case (1'b1)
        state == IDLE: begin
          if (in_valid) begin
            x     <= A;
            q_r   <= q;
            state <= PRE;
          end
        end
        state == PRE: begin
          x     <= x_pre;
          cnt   <= CW'(N);
          state <= RUN;
`ifdef MONT_ENTER_RANGE_CHK_EN
          err   <= ~q_r[Q_LEN-1];
`endif
        end
        state == RUN: begin
          x   <= x_nxt;
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1))
            state <= DONE;
        end
        state == DONE: begin
          if (out_ready) begin
            state <= IDLE;
`ifdef MONT_ENTER_RANGE_CHK_EN
            err   <= 1'b0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Held low for as long as reset is asserted.
  assign in_ready  = rst && (state == IDLE);
  assign out_valid = (state == DONE);

`ifdef MONT_ENTER_RANGE_CHK_EN
  assign T = err ? '0 : x;
`else
  assign T = x;
`endif

endmodule

// File: tb/tb_mont_enter_serial.sv
// Directed bench for mont_enter_serial, Q_LEN=SHIFT=8, STEPS 1/2/4 side by side.
// Summary: "Simulation finished: <checks> checks, <errors> errors".
module tb_mont_enter_serial;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] q = '0;
  logic [7:0] a = '0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;
  logic [7:0] t1, t2, t4;
  logic       ir1, ir2, ir4;
  logic       ov1, ov2, ov4;
`ifdef MONT_ENTER_RANGE_CHK_EN
  logic       er1, er2, er4;
  logic       err_seen;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mont_enter_serial #(.Q_LEN(8), .SHIFT(8), .STEPS(1)) u1 (
    .clk(clk), .rst(rst), .q(q), .A(a), .in_valid(in_valid),
    .in_ready(ir1), .T(t1), .out_valid(ov1),
`ifdef MONT_ENTER_RANGE_CHK_EN
    .err(er1),
`endif
    .out_ready(out_ready));

  mont_enter_serial #(.Q_LEN(8), .SHIFT(8), .STEPS(2)) u2 (
    .clk(clk), .rst(rst), .q(q), .A(a), .in_valid(in_valid),
    .in_ready(ir2), .T(t2), .out_valid(ov2),
`ifdef MONT_ENTER_RANGE_CHK_EN
    .err(er2),
`endif
    .out_ready(out_ready));

  mont_enter_serial #(.Q_LEN(8), .SHIFT(8), .STEPS(4)) u4 (
    .clk(clk), .rst(rst), .q(q), .A(a), .in_valid(in_valid),
    .in_ready(ir4), .T(t4), .out_valid(ov4),
`ifdef MONT_ENTER_RANGE_CHK_EN
    .err(er4),
`endif
    .out_ready(out_ready));

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] golden(input int qv, input int av);
    return 8'(((av % qv) * 256) % qv);
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (!(ir1 && ir2 && ir4) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("in_ready_wait", {31'd0, ir1 & ir2 & ir4}, 1);
  endtask

  task automatic conv(input logic [7:0] qv, input logic [7:0] av,
                      input logic [7:0] exp, input string tag);
    int l1 = -1, l2 = -1, l4 = -1;
    logic [7:0] r1 = '0, r2 = '0, r4 = '0;
    wait_idle();
    q = qv; a = av; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    q = ~qv; a = ~av;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk); #1;
      if (ov1 && l1 < 0) begin
        l1 = e; r1 = t1;
`ifdef MONT_ENTER_RANGE_CHK_EN
        err_seen = er1;
`endif
      end
      if (ov2 && l2 < 0) begin l2 = e; r2 = t2; end
      if (ov4 && l4 < 0) begin l4 = e; r4 = t4; end
    end
    check({tag, "_t1"}, r1, exp);
    check({tag, "_t2"}, r2, exp);
    check({tag, "_t4"}, r4, exp);
    check({tag, "_lat1"}, l1, 9);
    check({tag, "_lat2"}, l2, 5);
    check({tag, "_lat4"}, l4, 3);
  endtask

  initial begin
    logic [7:0] rq, ra, ht;
    #2;
    check("rst_ov", {29'd0, ov1, ov2, ov4}, 0);
    check("rst_t", {8'd0, t1, t2, t4}, 0);
    check("rst_ir", {29'd0, ir1, ir2, ir4}, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("post_rst_ir", {29'd0, ir1, ir2, ir4}, 7);

    conv(8'd251, 8'd5, 8'd25, "a5");
    conv(8'd251, 8'd255, 8'd20, "a255");
    conv(8'd251, 8'd250, 8'd246, "a250");
    conv(8'd251, 8'd0, 8'd0, "a0");
    conv(8'd128, 8'd200, 8'd0, "q128");
    conv(8'd129, 8'd77, 8'd104, "q129");

    for (int i = 0; i < 300; i++) begin
      rq = 8'h80 | 8'($urandom_range(0, 127));
      ra = 8'($urandom_range(0, 255));
      conv(rq, ra, golden(int'(rq), int'(ra)), "rnd");
    end

    // Backpressure: results held in DONE.
    out_ready = 1'b0;
    conv(8'd251, 8'd5, 8'd25, "bp");
    ht = t1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("bp_ov", {29'd0, ov1, ov2, ov4}, 7);
      check("bp_t", {8'd0, t1, t2, t4}, {8'd0, ht, ht, ht});
      check("bp_ir", {29'd0, ir1, ir2, ir4}, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_rel_ov", {29'd0, ov1, ov2, ov4}, 0);
    check("bp_rel_ir", {29'd0, ir1, ir2, ir4}, 7);
    conv(8'd251, 8'd250, 8'd246, "bp_next");

    // Reset in the middle of a conversion.
    wait_idle();
    q = 8'd251; a = 8'd5; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("mid_rst_ov", {29'd0, ov1, ov2, ov4}, 0);
    check("mid_rst_t", {8'd0, t1, t2, t4}, 0);
    check("mid_rst_ir", {29'd0, ir1, ir2, ir4}, 0);
    repeat (3) @(posedge clk);
    #1;
    check("mid_rst_hold_ov", {29'd0, ov1, ov2, ov4}, 0);
    rst = 1'b1;
    conv(8'd251, 8'd5, 8'd25, "after_rst");

`ifdef MONT_ENTER_RANGE_CHK_EN
    conv(8'd100, 8'd7, 8'd0, "errq");
    check("err_set", {31'd0, err_seen}, 1);
    conv(8'd251, 8'd5, 8'd25, "errclr");
    check("err_clr", {31'd0, err_seen}, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
